// File: rtl/seg7_scan.sv
// Purpose : time-multiplexed 4-digit hex 7-segment driver with a dead time
//           between digits, per-frame shadow registers and leading-zero blanking.
// Ports   : clk, clr_n (sync active-low reset), segclk (scan strobe, sampled as
//           data), value/dp/blank_lz (display content), an/seg/dp_n (active-low
//           drive, registered), frame (one-cycle pulse per completed scan).
module seg7_scan #(
  parameter int unsigned DEAD_CYC = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        segclk,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam logic [7:0] DEAD = DEAD_CYC[7:0];

  logic        sync1, sync2, prev;
  logic        tick;
  logic [1:0]  idx;
  logic [15:0] sh_value;
  logic [3:0]  sh_dp;
  logic        sh_blank;
  logic [7:0]  cnt;

  logic [3:0]  nib;
  logic        upper_zero;
  logic        blank;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_n_d;

  // Rising edge of the synchronized scan strobe.
  assign tick = sync2 & ~prev;

  // Hex to active-low segments, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    nib        = sh_value[3:0];
    upper_zero = 1'b0;
    case (idx)
      2'd0: begin
        nib        = sh_value[3:0];
        upper_zero = 1'b0;              // rightmost digit always shown
      end
      2'd1: begin
        nib        = sh_value[7:4];
        upper_zero = (sh_value[15:4] == 12'h000);
      end
      2'd2: begin
        nib        = sh_value[11:8];
        upper_zero = (sh_value[15:8] == 8'h00);
      end
      default: begin
        nib        = sh_value[15:12];
        upper_zero = (sh_value[15:12] == 4'h0);
      end
    endcase

    // A lit decimal point keeps an otherwise-leading zero visible.
    blank = sh_blank & upper_zero & ~sh_dp[idx];

    an_d   = 4'b1111;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (!blank) begin
      seg_d  = hex7(nib);
      dp_n_d = ~sh_dp[idx];
      if (cnt == 8'd0) begin
        an_d = ~(4'b0001 << idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      // Sync chain resets high so a strobe already high gives no edge.
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      idx      <= 2'd0;
      sh_value <= 16'h0000;
      sh_dp    <= 4'h0;
      sh_blank <= 1'b0;
      cnt      <= 8'd0;
      frame    <= 1'b0;
      an       <= 4'b1111;
      seg      <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      sync1 <= segclk;
      sync2 <= sync1;
      prev  <= sync2;
      if (tick) begin
        idx <= idx + 2'd1;
        cnt <= DEAD;
        // Content only changes at a frame boundary to avoid tearing.
        if (idx == 2'd3) begin
          sh_value <= value;
          sh_dp    <= dp;
          sh_blank <= blank_lz;
        end
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      frame <= tick & (idx == 2'd3);
      an    <= an_d;
      seg   <= seg_d;
      dp_n  <= dp_n_d;
    end
  end

endmodule
